// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_arbiter
// Purpose  : Front end for a 32x2048 1rw1r SRAM macro. Port 0 (read/write)
//            is shared between host A and accelerator B; port 1 (read-only)
//            serves streaming reader C. All macro pins are registered and the
//            macro's two-edge read latency is presented as a fixed-latency
//            response (accept edge E0, rsp_valid high from E2 to E3).
// Ports    : wb_clk_i / wb_rst_i        clock (also macro clk0/clk1), sync reset
//            a_* / b_*                  valid/ready request, pulsed response
//            c_*                        read-only valid/ready request, response
//            sram_*0 / sram_*1          registered macro pins, macro read data
// Revision : 1.0 - initial release
// ============================================================================
module sram_port_arbiter #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WMASKS = 4,
    parameter int PRIO_FIXED = 0,
    parameter int MAX_WAIT   = 15
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    // requester A
    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic                  a_we,
    input  logic [NUM_WMASKS-1:0] a_wmask,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_rsp_valid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    // requester B
    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic                  b_we,
    input  logic [NUM_WMASKS-1:0] b_wmask,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_rsp_valid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    // requester C (read only, port 1)
    input  logic                  c_req_valid,
    output logic                  c_req_ready,
    input  logic [ADDR_WIDTH-1:0] c_addr,
    output logic                  c_rsp_valid,
    output logic [DATA_WIDTH-1:0] c_rdata,
    // SRAM macro port 0
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,
    // SRAM macro port 1
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);

    localparam logic [3:0] c_wait_max = 4'(MAX_WAIT);

    // arbiter state
    logic       r_last_b;      // 1 = most recent port-0 grant went to B
    logic [3:0] r_wait_cnt;    // cycles B has been left waiting

    // port-0 selection
    logic                  w_tie_to_b;
    logic                  w_gnt_a;
    logic                  w_gnt_b;
    logic                  w_p0_go;
    logic                  w_p0_we;
    logic [NUM_WMASKS-1:0] w_p0_wmask;
    logic [ADDR_WIDTH-1:0] w_p0_addr;
    logic [DATA_WIDTH-1:0] w_p0_wdata;
    logic                  w_collide;
    logic                  w_c_go;

    // registered macro pins
    logic                  r_csb0;
    logic                  r_web0;
    logic [NUM_WMASKS-1:0] r_wmask0;
    logic [ADDR_WIDTH-1:0] r_addr0;
    logic [DATA_WIDTH-1:0] r_din0;
    logic                  r_csb1;
    logic [ADDR_WIDTH-1:0] r_addr1;

    // read tag pipelines (stage 1 = pins driven, stage 2 = macro sampled)
    logic r_p0_rd1, r_p0_rd2;
    logic r_p0_tag1, r_p0_tag2;   // 1 = response belongs to B
    logic r_c_rd1, r_c_rd2;

    // responses
    logic                  r_a_rsp_valid;
    logic                  r_b_rsp_valid;
    logic                  r_c_rsp_valid;
    logic [DATA_WIDTH-1:0] r_a_rdata;
    logic [DATA_WIDTH-1:0] r_b_rdata;
    logic [DATA_WIDTH-1:0] r_c_rdata;

    // ------------------------------------------------------------------
    // Port-0 grant. On a tie, round-robin hands the port to whoever did not
    // win last; fixed mode favours A until B has waited MAX_WAIT cycles.
    // ------------------------------------------------------------------
    always_comb begin
        w_tie_to_b = (PRIO_FIXED == 0) ? !r_last_b : (r_wait_cnt == c_wait_max);
        w_gnt_a    = 1'b0;
        w_gnt_b    = 1'b0;
        if (!wb_rst_i) begin
            if (a_req_valid && b_req_valid) begin
                w_gnt_a = !w_tie_to_b;
                w_gnt_b = w_tie_to_b;
            end else begin
                w_gnt_a = a_req_valid;
                w_gnt_b = b_req_valid;
            end
        end
    end

    assign w_p0_go    = w_gnt_a | w_gnt_b;
    assign w_p0_we    = w_gnt_b ? b_we    : a_we;
    assign w_p0_wmask = w_gnt_b ? b_wmask : a_wmask;
    assign w_p0_addr  = w_gnt_b ? b_addr  : a_addr;
    assign w_p0_wdata = w_gnt_b ? b_wdata : a_wdata;

    // A real write to the address C wants would hit the macro on the same
    // edge as C's read; hold C off for that one cycle.
    assign w_collide = w_p0_go && w_p0_we && (|w_p0_wmask) && (w_p0_addr == c_addr);
    assign w_c_go    = c_req_valid && c_req_ready;

    assign a_req_ready = w_gnt_a;
    assign b_req_ready = w_gnt_b;
    assign c_req_ready = !wb_rst_i && !w_collide;

    // ------------------------------------------------------------------
    // Arbiter state
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_last_b   <= 1'b1;
            r_wait_cnt <= 4'd0;
        end else begin
            if (w_gnt_a) begin
                r_last_b <= 1'b0;
            end else if (w_gnt_b) begin
                r_last_b <= 1'b1;
            end
            // saturates so the counter can never wrap back past the limit
            if (w_gnt_b) begin
                r_wait_cnt <= 4'd0;
            end else if (b_req_valid && (r_wait_cnt != c_wait_max)) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Macro pins. Idle cycles deselect the port but keep address/data.
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_csb0   <= 1'b1;
            r_web0   <= 1'b1;
            r_wmask0 <= '0;
            r_addr0  <= '0;
            r_din0   <= '0;
            r_csb1   <= 1'b1;
            r_addr1  <= '0;
        end else begin
            if (w_p0_go) begin
                r_csb0   <= 1'b0;
                r_web0   <= !w_p0_we;
                r_wmask0 <= w_p0_wmask;
                r_addr0  <= w_p0_addr;
                r_din0   <= w_p0_wdata;
            end else begin
                r_csb0 <= 1'b1;
                r_web0 <= 1'b1;
            end
            if (w_c_go) begin
                r_csb1  <= 1'b0;
                r_addr1 <= c_addr;
            end else begin
                r_csb1 <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response pipeline: macro output is valid before E2, captured at E2.
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_p0_rd1      <= 1'b0;
            r_p0_rd2      <= 1'b0;
            r_p0_tag1     <= 1'b0;
            r_p0_tag2     <= 1'b0;
            r_c_rd1       <= 1'b0;
            r_c_rd2       <= 1'b0;
            r_a_rsp_valid <= 1'b0;
            r_b_rsp_valid <= 1'b0;
            r_c_rsp_valid <= 1'b0;
            r_a_rdata     <= '0;
            r_b_rdata     <= '0;
            r_c_rdata     <= '0;
        end else begin
            r_p0_rd1      <= w_p0_go && !w_p0_we;
            r_p0_tag1     <= w_gnt_b;
            r_p0_rd2      <= r_p0_rd1;
            r_p0_tag2     <= r_p0_tag1;
            r_c_rd1       <= w_c_go;
            r_c_rd2       <= r_c_rd1;
            r_a_rsp_valid <= r_p0_rd2 && !r_p0_tag2;
            r_b_rsp_valid <= r_p0_rd2 && r_p0_tag2;
            r_c_rsp_valid <= r_c_rd2;
            if (r_p0_rd2 && !r_p0_tag2) begin
                r_a_rdata <= sram_dout0;
            end
            if (r_p0_rd2 && r_p0_tag2) begin
                r_b_rdata <= sram_dout0;
            end
            if (r_c_rd2) begin
                r_c_rdata <= sram_dout1;
            end
        end
    end

    assign sram_csb0   = r_csb0;
    assign sram_web0   = r_web0;
    assign sram_wmask0 = r_wmask0;
    assign sram_addr0  = r_addr0;
    assign sram_din0   = r_din0;
    assign sram_csb1   = r_csb1;
    assign sram_addr1  = r_addr1;
    assign a_rsp_valid = r_a_rsp_valid;
    assign b_rsp_valid = r_b_rsp_valid;
    assign c_rsp_valid = r_c_rsp_valid;
    assign a_rdata     = r_a_rdata;
    assign b_rdata     = r_b_rdata;
    assign c_rdata     = r_c_rdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_port_arbiter
// Purpose  : Self-checking bench. A round-robin instance is driven against a
//            behavioural SRAM and checked by a scoreboard; a fixed-priority
//            instance shares the stimulus and has its grants checked.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_port_arbiter;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_req_valid, a_we, b_req_valid, b_we, c_req_valid;
    logic [3:0]  a_wmask, b_wmask;
    logic [10:0] a_addr, b_addr, c_addr;
    logic [31:0] a_wdata, b_wdata;

    logic        a_req_ready, b_req_ready, c_req_ready;
    logic        a_rsp_valid, b_rsp_valid, c_rsp_valid;
    logic [31:0] a_rdata, b_rdata, c_rdata;
    logic        sram_csb0, sram_web0, sram_csb1;
    logic [3:0]  sram_wmask0;
    logic [10:0] sram_addr0, sram_addr1;
    logic [31:0] sram_din0, sram_dout0, sram_dout1;

    logic        fx_a_req_ready, fx_b_req_ready, fx_c_req_ready;
    logic        fx_a_rsp_valid, fx_b_rsp_valid, fx_c_rsp_valid;
    logic [31:0] fx_a_rdata, fx_b_rdata, fx_c_rdata;
    logic        fx_csb0, fx_web0, fx_csb1;
    logic [3:0]  fx_wmask0;
    logic [10:0] fx_addr0, fx_addr1;
    logic [31:0] fx_din0;

    sram_port_arbiter #(.PRIO_FIXED(0)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_we(a_we),
        .a_wmask(a_wmask), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rsp_valid(a_rsp_valid), .a_rdata(a_rdata),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_we(b_we),
        .b_wmask(b_wmask), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rsp_valid(b_rsp_valid), .b_rdata(b_rdata),
        .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_addr(c_addr),
        .c_rsp_valid(c_rsp_valid), .c_rdata(c_rdata),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
        .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
    );

    sram_port_arbiter #(.PRIO_FIXED(1), .MAX_WAIT(15)) dut_fx (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .a_req_valid(a_req_valid), .a_req_ready(fx_a_req_ready), .a_we(a_we),
        .a_wmask(a_wmask), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rsp_valid(fx_a_rsp_valid), .a_rdata(fx_a_rdata),
        .b_req_valid(b_req_valid), .b_req_ready(fx_b_req_ready), .b_we(b_we),
        .b_wmask(b_wmask), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rsp_valid(fx_b_rsp_valid), .b_rdata(fx_b_rdata),
        .c_req_valid(c_req_valid), .c_req_ready(fx_c_req_ready), .c_addr(c_addr),
        .c_rsp_valid(fx_c_rsp_valid), .c_rdata(fx_c_rdata),
        .sram_csb0(fx_csb0), .sram_web0(fx_web0), .sram_wmask0(fx_wmask0),
        .sram_addr0(fx_addr0), .sram_din0(fx_din0), .sram_dout0(sram_dout0),
        .sram_csb1(fx_csb1), .sram_addr1(fx_addr1), .sram_dout1(sram_dout1)
    );

    // ---------------- behavioural 1rw1r macro: sample on rise, act on fall
    logic [31:0] mem [0:2047];
    logic        l_csb0 = 1'b1, l_web0 = 1'b1, l_csb1 = 1'b1;
    logic [3:0]  l_wmask0;
    logic [10:0] l_addr0, l_addr1;
    logic [31:0] l_din0;

    always @(posedge clk) begin
        l_csb0   <= sram_csb0;
        l_web0   <= sram_web0;
        l_wmask0 <= sram_wmask0;
        l_addr0  <= sram_addr0;
        l_din0   <= sram_din0;
        l_csb1   <= sram_csb1;
        l_addr1  <= sram_addr1;
    end

    always @(negedge clk) begin
        if (l_csb0 === 1'b0) begin
            if (l_web0 === 1'b0) begin
                for (int i = 0; i < 4; i++)
                    if (l_wmask0[i]) mem[l_addr0][8*i +: 8] <= l_din0[8*i +: 8];
            end else begin
                sram_dout0 <= mem[l_addr0];
            end
        end
        if (l_csb1 === 1'b0) sram_dout1 <= mem[l_addr1];
    end

    // ---------------- reference model and scoreboard
    logic [31:0] ref_mem [0:2047];
    rsp_t        q [3][$];
    logic        m_last_b;
    int          m_wait;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        s_a, s_b, s_c, s_fb;   // ready values seen in the last cycle

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic arb(input logic va, input logic vb, input logic tie_b,
                       output logic ga, output logic gb);
        ga = va && (!vb || !tie_b);
        gb = vb && (!va || tie_b);
    endtask

    // One clock: check readies against the model mid-cycle, then commit.
    task automatic cycle();
        logic ga, gb, gc, fga, fgb, pwe;
        logic [3:0]  pm;
        logic [10:0] pa;
        logic [31:0] pd;
        rsp_t e;
        @(negedge clk);
        ga = 0; gb = 0; gc = 0; fga = 0; fgb = 0;
        pwe = 0; pm = '0; pa = '0; pd = '0;
        if (!rst) begin
            arb(a_req_valid, b_req_valid, !m_last_b, ga, gb);
            arb(a_req_valid, b_req_valid, (m_wait == 15), fga, fgb);
            pwe = gb ? b_we    : a_we;
            pm  = gb ? b_wmask : a_wmask;
            pa  = gb ? b_addr  : a_addr;
            pd  = gb ? b_wdata : a_wdata;
            gc  = !((ga || gb) && pwe && (pm != 4'd0) && (pa == c_addr));
        end
        s_a = a_req_ready; s_b = b_req_ready; s_c = c_req_ready; s_fb = fx_b_req_ready;
        chk("a_req_ready", a_req_ready, ga);
        chk("b_req_ready", b_req_ready, gb);
        chk("c_req_ready", c_req_ready, gc);
        chk("fixed a_req_ready", fx_a_req_ready, fga);
        chk("fixed b_req_ready", fx_b_req_ready, fgb);
        @(posedge clk);
        cyc++;
        if (rst) begin
            for (int p = 0; p < 3; p++) q[p].delete();
            m_last_b = 1'b1;
            m_wait   = 0;
        end else begin
            if (ga || gb) begin
                if (pwe) begin
                    for (int i = 0; i < 4; i++)
                        if (pm[i]) ref_mem[pa][8*i +: 8] = pd[8*i +: 8];
                end else begin
                    e.due = cyc + 2; e.data = ref_mem[pa];
                    q[gb ? 1 : 0].push_back(e);
                end
                m_last_b = gb;
            end
            if (gc && c_req_valid) begin
                e.due = cyc + 2; e.data = ref_mem[c_addr];
                q[2].push_back(e);
            end
            if (fgb) m_wait = 0;
            else if (b_req_valid && m_wait < 15) m_wait++;
        end
        #1;
    endtask

    task automatic mon_port(input int p, input logic v, input logic [31:0] d);
        string nm [3] = '{"a", "b", "c"};
        rsp_t e;
        if (v === 1'b1) begin
            if (q[p].size() == 0) begin
                checks++; errors++;
                $display("FAIL %s_rsp_valid unexpected: got 1 expected 0 (cycle %0d)", nm[p], cyc);
            end else begin
                e = q[p].pop_front();
                chk({nm[p], "_rdata"}, d, e.data);
                chk({nm[p], "_rsp cycle"}, cyc, e.due);
            end
        end else if (q[p].size() > 0 && q[p][0].due <= cyc) begin
            checks++; errors++;
            $display("FAIL %s_rsp_valid missing: got 0 expected 1 (cycle %0d)", nm[p], cyc);
            void'(q[p].pop_front());
        end
    endtask

    always @(posedge clk) begin
        #1;
        mon_port(0, a_rsp_valid, a_rdata);
        mon_port(1, b_rsp_valid, b_rdata);
        mon_port(2, c_rsp_valid, c_rdata);
    end

    task automatic set_idle();
        a_req_valid = 0; a_we = 0; a_wmask = '0; a_addr = '0; a_wdata = '0;
        b_req_valid = 0; b_we = 0; b_wmask = '0; b_addr = '0; b_wdata = '0;
        c_req_valid = 0; c_addr = '0;
    endtask

    task automatic a_cmd(input logic we, input logic [3:0] m, input logic [10:0] ad,
                         input logic [31:0] d);
        a_req_valid = 1; a_we = we; a_wmask = m; a_addr = ad; a_wdata = d;
    endtask

    initial begin
        int waited;
        for (int i = 0; i < 2048; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        sram_dout0 = '0; sram_dout1 = '0;
        m_last_b = 1'b1; m_wait = 0;
        set_idle();
        rst = 1;
        repeat (3) cycle();

        // reset state
        chk("sram_csb0 reset", sram_csb0, 1);
        chk("sram_csb1 reset", sram_csb1, 1);
        chk("sram_web0 reset", sram_web0, 1);
        chk("sram_wmask0 reset", sram_wmask0, 0);
        chk("sram_addr0 reset", sram_addr0, 0);
        chk("sram_addr1 reset", sram_addr1, 0);
        chk("sram_din0 reset", sram_din0, 0);
        chk("rsp_valid reset", {a_rsp_valid, b_rsp_valid, c_rsp_valid}, 0);
        chk("rdata reset", a_rdata | b_rdata | c_rdata, 0);
        rst = 0;

        // write then read-next-cycle
        a_cmd(1, 4'hF, 11'h005, 32'hDEADBEEF); cycle();
        a_cmd(0, 4'h0, 11'h005, 32'h0);        cycle();
        set_idle(); repeat (4) cycle();
        chk("a_rdata after write/read", a_rdata, 32'hDEADBEEF);

        // byte-masked write
        a_cmd(1, 4'hF, 11'h7FF, 32'h11223344);  cycle();
        a_cmd(1, 4'b0101, 11'h7FF, 32'hAABBCCDD); cycle();
        a_cmd(0, 4'h0, 11'h7FF, 32'h0);          cycle();
        set_idle(); repeat (4) cycle();
        chk("a_rdata byte mask", a_rdata, 32'h11BB33DD);

        // collision guard: C blocked for one cycle, then sees new word
        a_cmd(1, 4'hF, 11'h100, 32'hCAFEF00D);
        c_req_valid = 1; c_addr = 11'h100;
        cycle();
        chk("c_req_ready on collision", s_c, 0);
        a_req_valid = 0;
        cycle();
        chk("c_req_ready after collision", s_c, 1);
        set_idle(); repeat (4) cycle();
        chk("c_rdata after collision", c_rdata, 32'hCAFEF00D);

        // reset between accept and response
        a_cmd(0, 4'h0, 11'h005, 32'h0); cycle();
        set_idle(); rst = 1; cycle();
        rst = 0; repeat (4) cycle();
        chk("sram_csb0 after reset", sram_csb0, 1);
        chk("rdata after reset", a_rdata | b_rdata | c_rdata, 0);

        // continuous A and B reads: round-robin alternation, fixed-mode starvation limit
        waited = 0;
        for (int k = 0; k < 40; k++) begin
            a_cmd(0, 4'h0, 11'($urandom_range(0, 2047)), 32'h0);
            b_req_valid = 1; b_we = 0; b_addr = 11'($urandom_range(0, 2047));
            cycle();
            if (k < 8) chk("round-robin alternation", s_a, (k % 2 == 0));
            if (s_fb) begin
                chk("fixed B waited cycles", waited, 15);
                waited = 0;
            end else begin
                waited++;
            end
        end
        set_idle(); repeat (4) cycle();

        // randomized traffic on a small address window
        for (int k = 0; k < 500; k++) begin
            a_req_valid = ($urandom_range(0, 9) < 6);
            a_we = $urandom_range(0, 1); a_wmask = 4'($urandom);
            a_addr = 11'($urandom_range(0, 7)); a_wdata = $urandom;
            b_req_valid = ($urandom_range(0, 9) < 6);
            b_we = $urandom_range(0, 1); b_wmask = 4'($urandom);
            b_addr = 11'($urandom_range(0, 7)); b_wdata = $urandom;
            c_req_valid = ($urandom_range(0, 9) < 6);
            c_addr = 11'($urandom_range(0, 7));
            rst = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 0; set_idle(); repeat (6) cycle();
        chk("scoreboard drained", q[0].size() + q[1].size() + q[2].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
